// File: rtl/jtdsp16_do_loop.sv
// -----------------------------------------------------------------------------
// jtdsp16_do_loop
// DO/REDO loop sequencer for the DSP16 core. Decodes the loop count K and the
// loop length NI from the do/redo instruction field, steps the in-cache
// instruction offset and counts the remaining passes. Its strobes drive the
// do_* control inputs of the ROM address arithmetic unit so that fetch can
// switch between the cache window and the normal program counter.
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   cen       clock enable; state advances only when high
//   do_cmd    do instruction in execute this cycle
//   redo_cmd  redo instruction in execute this cycle
//   do_data   {NI, K} instruction field
//   do_start  loop begins this cycle (combinational)
//   do_redo   accepted command is a redo (combinational)
//   do_save   latch the cache head; accepted do only (combinational)
//   do_short  accepted loop has NI==1 (combinational)
//   do_out    final cached instruction is being fetched (combinational)
//   do_pc     registered cache offset, 1..NI in LOOP, 0 otherwise
//   do_busy   registered, high while in LOOP (used to block IRQs)
//   do_iter   registered remaining passes, including the current one
//   nest_err  sticky flag: do/redo arrived while a loop was running
// -----------------------------------------------------------------------------
module jtdsp16_do_loop #(
    parameter int KW  = 7,
    parameter int NIW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               do_cmd,
    input  logic               redo_cmd,
    input  logic [KW+NIW-1:0]  do_data,
    output logic               do_start,
    output logic               do_redo,
    output logic               do_save,
    output logic               do_short,
    output logic               do_out,
    output logic [NIW-1:0]     do_pc,
    output logic               do_busy,
    output logic [KW-1:0]      do_iter,
    output logic               nest_err
);

    typedef enum logic {
        IDLE = 1'b0,
        LOOP = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NIW-1:0]  ni_q, ni_d;
    logic [NIW-1:0]  pc_q, pc_d;
    logic [KW-1:0]   iter_q, iter_d;
    logic            nest_q, nest_d;

    logic [KW-1:0]   k_field_s;
    logic [NIW-1:0]  ni_field_s;
    logic [KW-1:0]   k_init_s;
    logic            accept_do_s;
    logic            accept_redo_s;
    logic            in_idle_s;
    logic            in_loop_s;
    logic            last_s;

    assign k_field_s  = do_data[KW-1:0];
    assign ni_field_s = do_data[KW+NIW-1:KW];

    // K==0 behaves as a single pass so the counter never starts at zero.
    assign k_init_s = (k_field_s == '0) ? KW'(1) : k_field_s;

    // A do with NI==0 is a no-op; a redo needs a length left by an earlier do.
    // do_cmd wins when both commands are present.
    assign accept_do_s   = do_cmd && (ni_field_s != '0);
    assign accept_redo_s = !do_cmd && redo_cmd && (ni_q != '0);

    assign in_idle_s = (state_q == IDLE);
    assign in_loop_s = (state_q == LOOP);
    assign last_s    = (pc_q == ni_q) && (iter_q == KW'(1));

    // Strobes are qualified by cen and the state so they stay low while frozen.
    assign do_start = cen && in_idle_s && (accept_do_s || accept_redo_s);
    assign do_save  = cen && in_idle_s && accept_do_s;
    assign do_redo  = cen && in_idle_s && accept_redo_s;
    assign do_short = do_start &&
                      (accept_do_s ? (ni_field_s == NIW'(1)) : (ni_q == NIW'(1)));
    assign do_out   = cen && in_loop_s && last_s;

    assign do_pc    = pc_q;
    assign do_busy  = in_loop_s;
    assign do_iter  = iter_q;
    assign nest_err = nest_q;

    // Next-state logic for the loop sequencer.
    always_comb begin
        state_d = state_q;
        ni_d    = ni_q;
        pc_d    = pc_q;
        iter_d  = iter_q;
        nest_d  = nest_q;
        if (cen) begin
            case (state_q)
                IDLE: begin
                    if (accept_do_s) begin
                        ni_d    = ni_field_s;
                        iter_d  = k_init_s;
                        pc_d    = NIW'(1);
                        state_d = LOOP;
                    end else if (accept_redo_s) begin
                        iter_d  = k_init_s;
                        pc_d    = NIW'(1);
                        state_d = LOOP;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOOP: begin
                    // Nested commands are dropped; only the sticky flag records them.
                    if (do_cmd || redo_cmd) begin
                        nest_d = 1'b1;
                    end else begin
                        nest_d = nest_q;
                    end
                    if (pc_q < ni_q) begin
                        pc_d = pc_q + NIW'(1);
                    end else if (iter_q > KW'(1)) begin
                        pc_d   = NIW'(1);
                        iter_d = iter_q - KW'(1);
                    end else begin
                        state_d = IDLE;
                        pc_d    = '0;
                        iter_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    pc_d    = '0;
                    iter_d  = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State registers; reset takes effect regardless of cen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ni_q    <= '0;
            pc_q    <= '0;
            iter_q  <= '0;
            nest_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ni_q    <= ni_d;
            pc_q    <= pc_d;
            iter_q  <= iter_d;
            nest_q  <= nest_d;
        end
    end

endmodule

// File: tb/tb_jtdsp16_do_loop.sv
module tb_jtdsp16_do_loop;

    logic        clk;
    logic        rst;
    logic        cen;
    logic        do_cmd;
    logic        redo_cmd;
    logic [10:0] do_data;
    logic        do_start;
    logic        do_redo;
    logic        do_save;
    logic        do_short;
    logic        do_out;
    logic [3:0]  do_pc;
    logic        do_busy;
    logic [6:0]  do_iter;
    logic        nest_err;

    int checks   = 0;
    int failures = 0;

    jtdsp16_do_loop dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .do_cmd   (do_cmd),
        .redo_cmd (redo_cmd),
        .do_data  (do_data),
        .do_start (do_start),
        .do_redo  (do_redo),
        .do_save  (do_save),
        .do_short (do_short),
        .do_out   (do_out),
        .do_pc    (do_pc),
        .do_busy  (do_busy),
        .do_iter  (do_iter),
        .nest_err (nest_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // start, save, redo, short, out
    task automatic strobes(input string tag, input logic s, input logic sv,
                           input logic r, input logic sh, input logic o);
        check({tag, ".start"}, {31'd0, do_start}, {31'd0, s});
        check({tag, ".save"},  {31'd0, do_save},  {31'd0, sv});
        check({tag, ".redo"},  {31'd0, do_redo},  {31'd0, r});
        check({tag, ".short"}, {31'd0, do_short}, {31'd0, sh});
        check({tag, ".out"},   {31'd0, do_out},   {31'd0, o});
    endtask

    task automatic regs(input string tag, input logic b, input int pc, input int it);
        check({tag, ".busy"}, {31'd0, do_busy}, {31'd0, b});
        check({tag, ".pc"},   {28'd0, do_pc},   pc);
        check({tag, ".iter"}, {25'd0, do_iter}, it);
    endtask

    // Move to the sampling point: inputs are set after this, then settle.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        do_cmd   = 1'b0;
        redo_cmd = 1'b0;
        do_data  = 11'd0;
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1;
        idle_inputs();
        tick(); tick();
        rst = 1'b0;
        settle();
        regs("reset", 1'b0, 0, 0);
        strobes("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.nest", {31'd0, nest_err}, 32'd0);

        // do NI=3 K=2
        tick(); do_cmd = 1'b1; do_data = {4'd3, 7'd2}; settle();
        strobes("do3x2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        regs("do3x2.pre", 1'b0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick(); idle_inputs(); settle();
            regs("do3x2.loop", 1'b1, (i % 3) + 1, (i < 3) ? 2 : 1);
            strobes("do3x2.loop", 1'b0, 1'b0, 1'b0, 1'b0, (i == 5));
        end
        tick(); settle();
        regs("do3x2.exit", 1'b0, 0, 0);
        check("do3x2.exit.out", {31'd0, do_out}, 32'd0);

        // redo K=3 reuses ni=3; NI field is ignored for redo
        tick(); redo_cmd = 1'b1; do_data = {4'd0, 7'd3}; settle();
        strobes("redo3", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            tick(); idle_inputs(); settle();
            regs("redo3.loop", 1'b1, (i % 3) + 1, 3 - (i / 3));
            check("redo3.loop.out", {31'd0, do_out}, {31'd0, (i == 8)});
        end
        tick(); settle();
        regs("redo3.exit", 1'b0, 0, 0);

        // redo right after reset is ignored
        rst = 1'b1; tick(); rst = 1'b0;
        redo_cmd = 1'b1; do_data = {4'd2, 7'd2}; settle();
        strobes("redo_norst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); idle_inputs(); settle();
        regs("redo_norst.after", 1'b0, 0, 0);

        // do with NI=0 is a no-op
        tick(); do_cmd = 1'b1; do_data = {4'd0, 7'd5}; settle();
        strobes("ni0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); idle_inputs(); settle();
        regs("ni0.after", 1'b0, 0, 0);

        // both commands high: do wins (NI=1 K=4 short loop)
        tick(); do_cmd = 1'b1; redo_cmd = 1'b1; do_data = {4'd1, 7'd4}; settle();
        strobes("short4", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); idle_inputs(); settle();
            regs("short4.loop", 1'b1, 1, 4 - i);
            check("short4.loop.out", {31'd0, do_out}, {31'd0, (i == 3)});
        end
        tick(); settle();
        regs("short4.exit", 1'b0, 0, 0);

        // K=0 counts as one pass
        tick(); do_cmd = 1'b1; do_data = {4'd1, 7'd0}; settle();
        strobes("k0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); idle_inputs(); settle();
        regs("k0.loop", 1'b1, 1, 1);
        check("k0.loop.out", {31'd0, do_out}, 32'd1);
        tick(); settle();
        regs("k0.exit", 1'b0, 0, 0);

        // cen=0 blocks acceptance
        tick(); cen = 1'b0; do_cmd = 1'b1; do_data = {4'd2, 7'd2}; settle();
        strobes("cen0.cmd", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); idle_inputs(); settle();
        regs("cen0.after", 1'b0, 0, 0);

        // NI=2 K=2 with cen alternating during the loop
        tick(); cen = 1'b1; do_cmd = 1'b1; do_data = {4'd2, 7'd2}; settle();
        strobes("cen.do", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            int k;
            k = j / 2;   // cen-high LOOP cycles already completed
            tick(); idle_inputs(); cen = (j % 2 == 1); settle();
            regs("cen.loop", 1'b1, (k % 2) + 1, 2 - (k / 2));
            check("cen.loop.out", {31'd0, do_out}, {31'd0, (j == 7)});
        end
        tick(); cen = 1'b1; settle();
        regs("cen.exit", 1'b0, 0, 0);

        // nested do mid-loop, then reset mid-loop
        tick(); do_cmd = 1'b1; do_data = {4'd3, 7'd2}; settle();
        strobes("nest.do", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); idle_inputs(); settle();
        regs("nest.c0", 1'b1, 1, 2);
        tick(); do_cmd = 1'b1; do_data = {4'd1, 7'd5}; settle();
        strobes("nest.cmd", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        regs("nest.c1", 1'b1, 2, 2);
        check("nest.pre", {31'd0, nest_err}, 32'd0);
        tick(); idle_inputs(); rst = 1'b1; settle();
        regs("nest.c2", 1'b1, 3, 2);
        check("nest.set", {31'd0, nest_err}, 32'd1);
        check("nest.rst.out", {31'd0, do_out}, 32'd0);
        tick(); rst = 1'b0; settle();
        regs("nest.rst", 1'b0, 0, 0);
        check("nest.clr", {31'd0, nest_err}, 32'd0);
        check("nest.rst.out2", {31'd0, do_out}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
